// File: rtl/prog_encoder.sv
// Instruction encoder/loader: packs one-hot class requests plus a 6-bit field into
// 8-bit opcodes and streams them into program memory at consecutive addresses.
module prog_encoder #(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DEPTH  = 256,
   parameter int unsigned UUID   = 0,
   parameter string       NAME   = ""
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              START,
   input  logic              DONE_REQ,
   input  logic              IN_VALID,
   output logic              IN_READY,
   input  logic              IMMEDIATE,
   input  logic              CALCULATION,
   input  logic              COPY,
   input  logic              CONDITION,
   input  logic [5:0]        FIELD,
   output logic [ADDR_W-1:0] MEM_ADDR,
   output logic [7:0]        MEM_DATA,
   output logic              MEM_WE,
   input  logic              MEM_READY,
   output logic [ADDR_W:0]   COUNT,
   output logic              BUSY,
   output logic              FULL,
   output logic              ERR
);

   localparam int unsigned     CW      = ADDR_W + 2;
   localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_DONE
   } state_e;

   // Identification only; the labels never affect the datapath.
   if ((UUID == 32'hFFFF_FFFF) && (NAME == "?")) begin : g_instance_tag
   end

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q,  addr_d;
   logic [7:0]          data_q,  data_d;
   logic [ADDR_W:0]     count_q, count_d;
   logic                we_q,    we_d;
   logic                err_q,   err_d;
   logic                full_q,  full_d;
   logic                drain_q, drain_d;

   logic [3:0]          sel;
   logic                sel_ok;
   logic [7:0]          opcode;
   logic                wr_done;
   logic                in_ready;
   logic                accept;

   assign sel    = {CONDITION, COPY, CALCULATION, IMMEDIATE};
   assign sel_ok = $onehot(sel);

   always_comb begin
      case (sel)
         4'b0010: opcode = {2'b01, 3'b000, FIELD[2:0]};
         4'b0100: opcode = {2'b10, FIELD};
         4'b1000: opcode = {2'b11, 3'b000, FIELD[2:0]};
         default: opcode = {2'b00, FIELD};
      endcase
   end

   assign wr_done = we_q & MEM_READY;

   // Room is counted including the write still in flight, so COUNT never overshoots DEPTH.
   assign in_ready = (state_q == ST_LOAD) & (~we_q | MEM_READY) &
                     (({1'b0, count_q} + CW'(we_q)) < DEPTH_C) & ~drain_q;
   assign accept   = IN_VALID & in_ready;

   always_comb begin
      // NOTE: every next-state signal gets a default first so no path can infer a latch.
      state_d = state_q;
      addr_d  = addr_q;
      data_d  = data_q;
      count_d = count_q;
      we_d    = we_q;
      full_d  = full_q;
      drain_d = drain_q;
      err_d   = 1'b0;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (START) begin
               state_d = ST_LOAD;
               addr_d  = '0;
               count_d = '0;
               full_d  = 1'b0;
               drain_d = 1'b0;
               we_d    = 1'b0;
            end
         end

         ST_LOAD: begin
            if (wr_done) begin
               addr_d  = addr_q + ADDR_W'(1);
               count_d = count_q + (ADDR_W + 1)'(1);
               we_d    = 1'b0;
            end
            if (accept) begin
               if (sel_ok) begin
                  we_d   = 1'b1;
                  data_d = opcode;
               end else begin
                  err_d  = 1'b1;
               end
            end
            if (DONE_REQ) drain_d = 1'b1;

            // A drain request waits for any write accepted on the same edge.
            if ({1'b0, count_d} == DEPTH_C) begin
               state_d = ST_DONE;
               full_d  = 1'b1;
            end else if (drain_d && !we_d) begin
               state_d = ST_DONE;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         data_q  <= '0;
         count_q <= '0;
         we_q    <= 1'b0;
         err_q   <= 1'b0;
         full_q  <= 1'b0;
         drain_q <= 1'b0;
      end else begin
         // NOTE: non-blocking updates keep every flop sampling pre-edge values.
         state_q <= state_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         count_q <= count_d;
         we_q    <= we_d;
         err_q   <= err_d;
         full_q  <= full_d;
         drain_q <= drain_d;
      end
   end

   assign IN_READY = in_ready;
   assign MEM_ADDR = addr_q;
   assign MEM_DATA = data_q;
   assign MEM_WE   = we_q;
   assign COUNT    = count_q;
   assign BUSY     = (state_q == ST_LOAD);
   assign FULL     = full_q;
   assign ERR      = err_q;

endmodule

// File: tb/tb_prog_encoder.sv
// Directed bench for prog_encoder (DEPTH=4): a scoreboard queue holds the expected
// memory writes, popped and compared whenever the DUT completes a write.
module tb_prog_encoder;

   localparam int ADDR_W = 8;
   localparam int DEPTH  = 4;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              START = 1'b0;
   logic              DONE_REQ = 1'b0;
   logic              IN_VALID = 1'b0;
   logic              IMMEDIATE = 1'b0;
   logic              CALCULATION = 1'b0;
   logic              COPY = 1'b0;
   logic              CONDITION = 1'b0;
   logic [5:0]        FIELD = '0;
   logic              MEM_READY = 1'b0;
   logic              IN_READY;
   logic [ADDR_W-1:0] MEM_ADDR;
   logic [7:0]        MEM_DATA;
   logic              MEM_WE;
   logic [ADDR_W:0]   COUNT;
   logic              BUSY;
   logic              FULL;
   logic              ERR;

   typedef struct packed {
      logic [7:0] addr;
      logic [7:0] data;
   } wr_t;

   wr_t        sb[$];
   wr_t        mon_e;
   logic [7:0] exp_addr = '0;
   int         n_checks = 0;
   int         n_fail   = 0;
   int         wr_cnt   = 0;
   int         waited;

   localparam logic [3:0] S_IMM  = 4'b0001;
   localparam logic [3:0] S_CALC = 4'b0010;
   localparam logic [3:0] S_COPY = 4'b0100;
   localparam logic [3:0] S_COND = 4'b1000;

   always #5 clk = ~clk;

   prog_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .UUID(7), .NAME("tb")) dut (
      .clk(clk), .rst(rst), .START(START), .DONE_REQ(DONE_REQ),
      .IN_VALID(IN_VALID), .IN_READY(IN_READY),
      .IMMEDIATE(IMMEDIATE), .CALCULATION(CALCULATION), .COPY(COPY), .CONDITION(CONDITION),
      .FIELD(FIELD), .MEM_ADDR(MEM_ADDR), .MEM_DATA(MEM_DATA), .MEM_WE(MEM_WE),
      .MEM_READY(MEM_READY), .COUNT(COUNT), .BUSY(BUSY), .FULL(FULL), .ERR(ERR)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_sel(input logic [3:0] sel);
      {CONDITION, COPY, CALCULATION, IMMEDIATE} = sel;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_in_ready"}, IN_READY, 0);
      check({tag, "_mem_we"},   MEM_WE,   0);
      check({tag, "_mem_addr"}, MEM_ADDR, 0);
      check({tag, "_mem_data"}, MEM_DATA, 0);
      check({tag, "_count"},    COUNT,    0);
      check({tag, "_busy"},     BUSY,     0);
      check({tag, "_full"},     FULL,     0);
      check({tag, "_err"},      ERR,      0);
   endtask

   task automatic start_session(input string tag);
      @(negedge clk);
      START = 1'b1;
      @(negedge clk);
      START = 1'b0;
      exp_addr = '0;
      #1;
      check({tag, "_busy"},  BUSY,     1);
      check({tag, "_count"}, COUNT,    0);
      check({tag, "_addr"},  MEM_ADDR, 0);
      check({tag, "_full"},  FULL,     0);
   endtask

   // Presents one request and waits (bounded) for the handshake.
   task automatic send(input logic [3:0] sel, input logic [5:0] f, input logic [7:0] exp_data,
                       input bit good, input bit exp_acc, input string tag, output int n_wait);
      bit acc = 1'b0;
      n_wait = 0;
      IN_VALID = 1'b1;
      set_sel(sel);
      FIELD = f;
      for (int i = 0; i < 6 && !acc; i++) begin
         #1;
         if (IN_READY) begin
            acc = 1'b1;
            n_wait = i;
            if (good) begin
               sb.push_back('{addr: exp_addr, data: exp_data});
               exp_addr++;
            end
         end
         @(negedge clk);
      end
      check({tag, "_accepted"}, acc, exp_acc);
      if (acc) begin
         #1;
         if (good) begin
            check({tag, "_we_lat1"},   MEM_WE,   1);
            check({tag, "_data_lat1"}, MEM_DATA, exp_data);
            check({tag, "_no_err"},    ERR,      0);
         end else begin
            check({tag, "_err"},   ERR,    1);
            check({tag, "_no_we"}, MEM_WE, 0);
         end
      end
   endtask

   // Write monitor: samples just before each rising edge.
   always @(negedge clk) begin
      #4;
      if (rst && MEM_WE && MEM_READY) begin
         wr_cnt++;
         check("sb_has_entry", (sb.size() != 0), 1);
         if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            check("wr_addr", MEM_ADDR, mon_e.addr);
            check("wr_data", MEM_DATA, mon_e.data);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset state
      #1;
      check_all_zero("reset");
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("idle_in_ready", IN_READY, 0);

      // Four classes back-to-back, then a fifth beyond DEPTH
      MEM_READY = 1'b1;
      start_session("s1");
      send(S_IMM,  6'h2A, 8'h2A, 1'b1, 1'b1, "imm",  waited); check("imm_wait",  waited, 0);
      send(S_CALC, 6'h3D, 8'h45, 1'b1, 1'b1, "calc", waited); check("calc_wait", waited, 0);
      send(S_COPY, 6'h1A, 8'h9A, 1'b1, 1'b1, "copy", waited); check("copy_wait", waited, 0);
      send(S_COND, 6'h05, 8'hC5, 1'b1, 1'b1, "cond", waited); check("cond_wait", waited, 0);
      send(S_IMM,  6'h01, 8'h01, 1'b1, 1'b0, "fifth", waited);
      IN_VALID = 1'b0;
      #1;
      check("s1_count",    COUNT,    4);
      check("s1_full",     FULL,     1);
      check("s1_busy",     BUSY,     0);
      check("s1_in_ready", IN_READY, 0);
      check("s1_addr",     MEM_ADDR, 4);
      check("s1_err",      ERR,      0);
      check("s1_writes",   wr_cnt,   4);

      // Stall with a write pending
      MEM_READY = 1'b0;
      start_session("s2");
      send(S_IMM, 6'h11, 8'h11, 1'b1, 1'b1, "stall_a", waited);
      IN_VALID = 1'b1;
      set_sel(S_COPY);
      FIELD = 6'h3F;
      for (int i = 0; i < 3; i++) begin
         check("stall_we",       MEM_WE,   1);
         check("stall_data",     MEM_DATA, 8'h11);
         check("stall_addr",     MEM_ADDR, 0);
         check("stall_in_ready", IN_READY, 0);
         @(negedge clk);
         #1;
      end
      MEM_READY = 1'b1;
      #1;
      check("release_in_ready", IN_READY, 1);
      sb.push_back('{addr: exp_addr, data: 8'hBF});
      exp_addr++;
      @(negedge clk);
      IN_VALID = 1'b0;
      #1;
      check("b_we",    MEM_WE,   1);
      check("b_data",  MEM_DATA, 8'hBF);
      check("b_addr",  MEM_ADDR, 1);
      check("b_count", COUNT,    1);
      @(negedge clk);
      #1;
      check("b_done_we", MEM_WE, 0);
      check("b_count2",  COUNT,  2);

      // Rejected selects
      send(S_IMM | S_COPY, 6'h12, 8'h00, 1'b0, 1'b1, "two_hot", waited);
      IN_VALID = 1'b0;
      check("two_hot_count", COUNT, 2);
      @(negedge clk);
      #1;
      check("err_one_cycle", ERR,    0);
      check("err_no_we",     MEM_WE, 0);
      send(4'b0000, 6'h00, 8'h00, 1'b0, 1'b1, "zero_hot", waited);
      send(S_COND, 6'h07, 8'hC7, 1'b1, 1'b1, "after_err", waited);
      IN_VALID = 1'b0;
      @(negedge clk);
      #1;
      check("s2_count", COUNT,    3);
      check("s2_addr",  MEM_ADDR, 3);

      // DONE_REQ with nothing pending, then ignored inputs in DONE
      DONE_REQ = 1'b1;
      @(negedge clk);
      DONE_REQ = 1'b0;
      #1;
      check("drain_busy",  BUSY,     0);
      check("drain_full",  FULL,     0);
      check("drain_count", COUNT,    3);
      IN_VALID = 1'b1;
      set_sel(4'b0000);
      #1;
      check("done_in_ready", IN_READY, 0);
      @(negedge clk);
      #1;
      check("done_no_err", ERR,    0);
      check("done_no_we",  MEM_WE, 0);
      IN_VALID = 1'b0;

      // Accept and DONE_REQ on the same edge, write stalled two cycles
      MEM_READY = 1'b0;
      start_session("s3");
      IN_VALID = 1'b1;
      set_sel(S_CALC);
      FIELD = 6'h2E;
      DONE_REQ = 1'b1;
      #1;
      check("dr_in_ready", IN_READY, 1);
      sb.push_back('{addr: exp_addr, data: 8'h46});
      exp_addr++;
      @(negedge clk);
      DONE_REQ = 1'b0;
      IN_VALID = 1'b0;
      for (int i = 0; i < 2; i++) begin
         #1;
         check("dr_we",       MEM_WE,   1);
         check("dr_busy",     BUSY,     1);
         check("dr_in_ready", IN_READY, 0);
         @(negedge clk);
      end
      MEM_READY = 1'b1;
      #1;
      check("dr_no_accept", IN_READY, 0);
      @(negedge clk);
      #1;
      check("dr_busy_end", BUSY,     0);
      check("dr_ready_end", IN_READY, 0);
      check("dr_we_end",   MEM_WE,   0);
      check("dr_count",    COUNT,    1);
      check("dr_addr",     MEM_ADDR, 1);

      // Asynchronous reset in the middle of a stalled write
      MEM_READY = 1'b0;
      start_session("s4");
      IN_VALID = 1'b1;
      set_sel(S_IMM);
      FIELD = 6'h15;
      #1;
      check("rw_in_ready", IN_READY, 1);
      @(negedge clk);
      IN_VALID = 1'b0;
      #1;
      check("rw_we",   MEM_WE,   1);
      check("rw_data", MEM_DATA, 8'h15);
      #2;
      rst = 1'b0;
      #1;
      check_all_zero("async_rst");
      @(negedge clk);
      rst = 1'b1;
      exp_addr = '0;
      IN_VALID = 1'b1;
      MEM_READY = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("post_rst_in_ready", IN_READY, 0);
         check("post_rst_busy",     BUSY,     0);
         check("post_rst_we",       MEM_WE,   0);
         @(negedge clk);
      end
      IN_VALID = 1'b0;

      start_session("s5");
      send(S_IMM, 6'h3C, 8'h3C, 1'b1, 1'b1, "final", waited);
      IN_VALID = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #1;
      check("final_count",  COUNT,     1);
      check("sb_drained",   sb.size(), 0);
      check("total_writes", wr_cnt,    9);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
